// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and load/store ports onto one word-wide memory; sub-word
// stores are done as read-modify-write, loads are lane-extracted and extended.
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
  localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + {1'b0, MEM_DEPTH_BYTES};

  typedef enum logic [1:0] {StIdle, StAccess, StMergeWr, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic            is_d_q, we_q, uns_q;
  logic [1:0]      size_q, lane_q;
  logic [15:0]     wdata_q;
  logic [31:0]     i_rdata_q, d_rdata_q, mem_addr_q, mem_wdata_q;
  logic            i_valid_q, d_valid_q, i_err_q, d_err_q, mem_rw_q;

  logic        grant_d, grant_i, req_err, misalign, range_bad;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [2:0]  acc_bytes;
  logic [32:0] end_addr;
  logic [4:0]  shamt;
  logic [31:0] lane_word, load_data, merge_data, byte_mask, half_mask;

  // Data wins ties unless fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    grant_d  = d_req && !(i_req && (starve_q == StarveMax));
    grant_i  = i_req && !grant_d;
    sel_addr = grant_d ? d_addr : i_addr;
    sel_size = grant_d ? d_size : 2'b10;
    case (sel_size)
      2'b00:   acc_bytes = 3'd1;
      2'b01:   acc_bytes = 3'd2;
      default: acc_bytes = 3'd4;
    endcase
    end_addr  = {1'b0, sel_addr} + {30'b0, acc_bytes};
    misalign  = (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                (sel_size == 2'b11);
    range_bad = (sel_addr < BASE_ADDR) || (end_addr > LimitAddr);
    req_err   = misalign || range_bad;
  end

  always_comb begin
    shamt     = {lane_q, 3'b000};
    lane_word = mem_data_out >> shamt;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
      default: load_data = mem_data_out;
    endcase
    byte_mask = 32'h0000_00FF << shamt;
    half_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
    if (size_q == 2'b00) begin
      merge_data = (mem_data_out & ~byte_mask) | ({24'b0, wdata_q[7:0]} << shamt);
    end else begin
      merge_data = (mem_data_out & ~half_mask) | ({16'b0, wdata_q} << {lane_q[1], 4'b0000});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      is_d_q      <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          mem_rw_q <= 1'b0;
          if (grant_i || !i_req) begin
            starve_q <= '0;
          end else if (grant_d) begin
            starve_q <= starve_q + CntW'(1);
          end
          if (grant_d || grant_i) begin
            is_d_q  <= grant_d;
            we_q    <= grant_d && d_we;
            size_q  <= sel_size;
            uns_q   <= d_unsigned;
            lane_q  <= sel_addr[1:0];
            wdata_q <= d_wdata[15:0];
            if (req_err) begin
              state_q <= StResp;
              if (grant_d) begin
                d_valid_q <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                i_valid_q <= 1'b1;
                i_err_q   <= 1'b1;
                i_rdata_q <= '0;
              end
            end else begin
              state_q    <= StAccess;
              mem_addr_q <= {sel_addr[31:2], 2'b00};
              if (grant_d) mem_wdata_q <= d_wdata;
              mem_rw_q   <= grant_d && d_we && (sel_size == 2'b10);
            end
          end
        end
        StAccess: begin
          if (is_d_q && we_q && size_q != 2'b10) begin
            state_q     <= StMergeWr;
            mem_rw_q    <= 1'b1;
            mem_wdata_q <= merge_data;
          end else begin
            state_q  <= StResp;
            mem_rw_q <= 1'b0;
            if (is_d_q) begin
              d_valid_q <= 1'b1;
              d_rdata_q <= we_q ? 32'h0 : load_data;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= mem_data_out;
            end
          end
        end
        StMergeWr: begin
          state_q   <= StResp;
          mem_rw_q  <= 1'b0;
          d_valid_q <= 1'b1;
          d_rdata_q <= '0;
        end
        default: begin
          state_q   <= StIdle;
          i_valid_q <= 1'b0;
          d_valid_q <= 1'b0;
          i_err_q   <= 1'b0;
          d_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata        = i_rdata_q;
  assign i_valid        = i_valid_q;
  assign i_err          = i_err_q;
  assign d_rdata        = d_rdata_q;
  assign d_valid        = d_valid_q;
  assign d_err          = d_err_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_in    = mem_wdata_q;
  assign mem_read_write = mem_rw_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small word-wide memory model.
module tb_mem_access_ctrl;

  localparam logic [31:0] Base = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;
  logic        i_valid, i_err, d_valid, d_err, mem_read_write;

  int passed = 0;
  int total  = 0;

  mem_access_ctrl #(
    .BASE_ADDR(32'h0100_0000),
    .MEM_DEPTH_BYTES(32'h0010_0000),
    .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_read_write(mem_read_write)
  );

  always #5 clock = ~clock;

  // 256-word memory, aliased on address bits [9:2].
  logic [31:0] mem [256];
  assign mem_data_out = mem[mem_address[9:2]];
  always @(posedge clock) if (mem_read_write) mem[mem_address[9:2]] <= mem_data_in;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic is_d, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat, input int mem_idx,
                              input logic [31:0] exp_mem);
    vec_t v;
    v.is_d = is_d; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.mem_idx = mem_idx; v.exp_mem = exp_mem;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_txn(input int id, input vec_t v);
    int n = 0;
    bit done = 0;
    bit rw_seen = 0;
    @(negedge clock);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(posedge clock);
    while (!done && n < 10) begin
      @(negedge clock);
      n++;
      if (mem_read_write) rw_seen = 1'b1;
      if (i_valid || d_valid) done = 1'b1;
    end
    check($sformatf("vec%0d_done", id), 32'(done), 32'd1);
    check($sformatf("vec%0d_latency", id), 32'(n), 32'(v.exp_lat));
    check($sformatf("vec%0d_valids", id), {30'b0, i_valid, d_valid},
          v.is_d ? 32'd1 : 32'd2);
    check($sformatf("vec%0d_err", id), 32'(v.is_d ? d_err : i_err), 32'(v.exp_err));
    if (!v.exp_err)
      check($sformatf("vec%0d_rdata", id), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    else
      check($sformatf("vec%0d_no_mem_write", id), 32'(rw_seen), 32'd0);
    if (v.mem_idx >= 0)
      check($sformatf("vec%0d_mem", id), mem[v.mem_idx], v.exp_mem);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    string order;
    string exp_order;
    int cyc;

    for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    mem[0]   <= 32'h0000_006F;
    mem[1]   <= 32'h1122_3344;
    mem[2]   <= 32'h8000_7FFF;
    mem[4]   <= 32'h0102_0304;
    mem[255] <= 32'hC35A_0F96;

    //        is_d we size uns addr          wdata         exp_rdata     err lat idx exp_mem
    vecs[0]  = mk(0, 0, 2'b10, 0, 32'h0100_0000, 32'h0,        32'h0000_006F, 0, 2, -1, 0);
    vecs[1]  = mk(1, 1, 2'b00, 0, 32'h0100_0005, 32'h0000_00AB, 32'h0,        0, 3, 1, 32'h1122_AB44);
    vecs[2]  = mk(1, 0, 2'b00, 0, 32'h0100_0005, 32'h0,        32'hFFFF_FFAB, 0, 2, -1, 0);
    vecs[3]  = mk(1, 0, 2'b00, 1, 32'h0100_0005, 32'h0,        32'h0000_00AB, 0, 2, -1, 0);
    vecs[4]  = mk(1, 0, 2'b01, 0, 32'h0100_0008, 32'h0,        32'h0000_7FFF, 0, 2, -1, 0);
    vecs[5]  = mk(1, 0, 2'b01, 0, 32'h0100_000A, 32'h0,        32'hFFFF_8000, 0, 2, -1, 0);
    vecs[6]  = mk(1, 0, 2'b01, 1, 32'h0100_000A, 32'h0,        32'h0000_8000, 0, 2, -1, 0);
    vecs[7]  = mk(1, 1, 2'b01, 0, 32'h0100_000A, 32'h1234_BEEF, 32'h0,        0, 3, 2, 32'hBEEF_7FFF);
    vecs[8]  = mk(1, 0, 2'b10, 0, 32'h0100_0008, 32'h0,        32'hBEEF_7FFF, 0, 2, -1, 0);
    vecs[9]  = mk(1, 1, 2'b10, 0, 32'h0100_000C, 32'hCAFE_F00D, 32'h0,        0, 2, 3, 32'hCAFE_F00D);
    vecs[10] = mk(1, 0, 2'b10, 0, 32'h0100_000C, 32'h0,        32'hCAFE_F00D, 0, 2, -1, 0);
    vecs[11] = mk(1, 1, 2'b00, 0, 32'h0100_0000, 32'hFFFF_FF80, 32'h0,        0, 3, 0, 32'h0000_0080);
    vecs[12] = mk(0, 0, 2'b10, 0, 32'h0100_0000, 32'h0,        32'h0000_0080, 0, 2, -1, 0);
    vecs[13] = mk(1, 0, 2'b10, 0, 32'h010F_FFFC, 32'h0,        32'hC35A_0F96, 0, 2, -1, 0);
    vecs[14] = mk(1, 0, 2'b00, 0, 32'h010F_FFFF, 32'h0,        32'hFFFF_FFC3, 0, 2, -1, 0);
    vecs[15] = mk(1, 0, 2'b01, 0, 32'h010F_FFFE, 32'h0,        32'hFFFF_C35A, 0, 2, -1, 0);
    vecs[16] = mk(1, 0, 2'b01, 0, 32'h0100_0003, 32'h0,        32'h0,        1, 1, -1, 0);
    vecs[17] = mk(0, 0, 2'b10, 0, 32'h00FF_FFFC, 32'h0,        32'h0,        1, 1, -1, 0);
    vecs[18] = mk(1, 0, 2'b10, 0, 32'h0110_0000, 32'h0,        32'h0,        1, 1, -1, 0);
    vecs[19] = mk(1, 0, 2'b11, 0, 32'h0100_0000, 32'h0,        32'h0,        1, 1, -1, 0);
    vecs[20] = mk(0, 0, 2'b10, 0, 32'h0100_0002, 32'h0,        32'h0,        1, 1, -1, 0);
    vecs[21] = mk(1, 1, 2'b10, 0, 32'h0100_0006, 32'hDEAD_BEEF, 32'h0,        1, 1, 1, 32'h1122_AB44);
    vecs[22] = mk(1, 0, 2'b00, 0, 32'h00FF_FFFF, 32'h0,        32'h0,        1, 1, -1, 0);

    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valids", {28'b0, i_valid, d_valid, i_err, d_err}, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_mem_address", mem_address, Base);
    check("rst_mem_data_in", mem_data_in, 32'h0);
    check("rst_mem_rw", 32'(mem_read_write), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      do_txn(i, vecs[i]);
      if (i == 14) check("i_rdata_hold", i_rdata, 32'h0000_0080);
    end

    // Both ports held: fetch gets through once every STARVE_LIMIT data grants.
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h0100_0000;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h0100_000C;
    order = "";
    cyc = 0;
    while (order.len() < 10 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (i_valid) order = {order, "I"};
      if (d_valid) order = {order, "D"};
    end
    i_req = 1'b0;
    d_req = 1'b0;
    exp_order = "DDDDIDDDDI";
    check("arb_count", 32'(order.len()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < order.len()) check($sformatf("arb_grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
      else check($sformatf("arb_grant%0d", k), 32'h0, 32'(exp_order[k]));
    end

    // Reset in the write half of a read-modify-write.
    @(negedge clock);
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h0100_0010; d_wdata = 32'h0000_00EE;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rmw_write_phase", 32'(mem_read_write), 32'h1);
    check("rmw_merged_data", mem_data_in, 32'h0102_03EE);
    reset_n = 1'b0;
    #1;
    check("rst_async_rw", 32'(mem_read_write), 32'h0);
    check("rst_async_valids", {30'b0, i_valid, d_valid}, 32'h0);
    check("rst_async_addr", mem_address, Base);
    d_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_mem_unchanged", mem[4], 32'h0102_0304);
    reset_n = 1'b1;
    do_txn(99, mk(1, 0, 2'b10, 0, 32'h0100_0010, 32'h0, 32'h0102_0304, 0, 2, -1, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Controller and arbiter that shares the single-port main memory (`mainmem`: combinational read, posedge word write, byte-addressed at BASE_ADDR) between the instruction-fetch port and the load/store port.
- Arbitrates the two ports, sequences each memory access, and handles byte/halfword loads (extract plus sign/zero extension).
- Implements sub-word stores as read-modify-write, because the memory writes whole 32-bit words only.
- Rejects misaligned and out-of-range accesses.

Parameters:
BASE_ADDR, 'h01000000, first byte address mapped to memory
MEM_DEPTH_BYTES, 'h0100000, size of the mapped region in bytes
STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_valid
i_addr  in  32  fetch byte address
i_rdata  out  32  fetched word
i_valid  out  1  one-cycle fetch completion pulse
i_err  out  1  with i_valid: misaligned or out-of-range
d_req  in  1  load/store request; held with fields until d_valid
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
d_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0)
d_addr  in  32  data byte address
d_wdata  in  32  store data, right-aligned
d_rdata  out  32  extended load data
d_valid  out  1  one-cycle data completion pulse
d_err  out  1  with d_valid: misaligned, out-of-range or reserved size
mem_address  out  32  to memory address
mem_data_in  out  32  to memory write data
mem_data_out  in  32  from memory read data
mem_read_write  out  1  0 = READ, 1 = WRITE

Behaviour:
- Reset (asynchronous, reset_n low): FSM goes to IDLE.
  - i_valid, d_valid, i_err, d_err = 0.
  - i_rdata, d_rdata, mem_data_in = 0.
  - mem_address = BASE_ADDR; mem_read_write = 0.
  - Starvation counter = 0.
  - A write in flight is dropped: mem_read_write falls immediately, so no memory write occurs.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - mem_read_write = 0.
  - At a posedge with any req high, the winner's fields are latched and the FSM goes to ACCESS.
  - If the request is invalid, the FSM goes straight to RESP with err set and no memory activity.
- Arbitration:
  - Data wins when both requests are high, unless the starvation counter equals STARVE_LIMIT; in that case fetch wins.
  - The counter increments on each data grant made while i_req is high.
  - The counter clears on any fetch grant, and in any IDLE cycle with i_req low.
- Invalid requests:
  - Halfword with addr[0] = 1.
  - Word or fetch with addr[1:0] != 0.
  - d_size = 11.
  - Address < BASE_ADDR, or address + access bytes > BASE_ADDR + MEM_DEPTH_BYTES.
- ACCESS:
  - mem_address = {addr[31:2], 2'b00}.
  - Word store: mem_read_write = 1 and mem_data_in = d_wdata; memory writes at the closing edge; next state RESP.
  - Load, fetch, or sub-word store: mem_read_write = 0 and mem_data_out is captured at the closing edge.
  - Loads and fetches go to RESP.
  - Sub-word stores go to MERGE_WR.
- MERGE_WR:
  - mem_read_write = 1.
  - mem_data_in = the captured word with the target lane replaced: byte = d_wdata[7:0] at lane addr[1:0]; half = d_wdata[15:0] at lane addr[1].
  - Next state RESP.
- RESP:
  - Exactly one of i_valid / d_valid is high for one cycle, with the matching rdata/err.
  - Loads: the selected lane is shifted to bit 0 and extended per d_unsigned.
  - Stores: d_rdata = 0.
  - The requester drops or changes req at the edge ending this cycle.
  - Next state IDLE (no back-to-back acceptance).
- Latency from the accepting edge to the valid cycle:
  - Load, fetch, word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Outside its own valid cycle, an idle port's rdata holds its last value; err is 0 whenever valid is 0.
- req changes while an access is in progress are ignored, because the fields are latched.

Test Plan:
- Fetch only, i_addr = 0x01000000, memory word 0x0000006F → i_valid exactly 2 cycles after acceptance with i_rdata = 0x0000006F, i_err = 0.
- Byte store d_addr = 0x01000005, d_wdata = 0xAB over word 0x11223344 → read then write; memory word = 0x1122AB44; d_valid 3 cycles after acceptance.
- Load byte at 0x01000005 after the previous store: d_unsigned = 0 → d_rdata = 0xFFFFFFAB; d_unsigned = 1 → d_rdata = 0x000000AB.
- Both req held continuously, STARVE_LIMIT = 4 → grant order D, D, D, D, I, D, D, D, D, I.
- Halfword load at 0x01000003 → d_valid and d_err 1 cycle after acceptance, mem_read_write stays 0. Fetch at 0x00FFFFFC → i_err.
- reset_n asserted during MERGE_WR → mem_read_write falls immediately, memory word unchanged, all valids 0. After release, a new word load completes normally.
